// File: rtl/alu_sequencer_if.sv
// Instruction, ALU, writeback and debug signals between the sequencer and its environment.
// The sequencer takes the slave view; the instruction source / ALU side takes the master view.
interface alu_sequencer_if;
  logic        i_instr_valid;
  logic [15:0] i_instr;
  logic        o_instr_ready;
  logic [3:0]  o_alu_opcode;
  logic [1:0]  o_alu_extra;
  logic [15:0] o_alu_data1;
  logic [15:0] o_alu_data2;
  logic [15:0] i_alu_data;
  logic        o_wb_valid;
  logic [1:0]  o_wb_reg;
  logic [15:0] o_wb_data;
  logic        o_illegal;
  logic [1:0]  i_dbg_reg;
  logic [15:0] o_dbg_data;

  modport slave (
    input  i_instr_valid, i_instr, i_alu_data, i_dbg_reg,
    output o_instr_ready, o_alu_opcode, o_alu_extra, o_alu_data1, o_alu_data2,
           o_wb_valid, o_wb_reg, o_wb_data, o_illegal, o_dbg_data
  );

  modport master (
    output i_instr_valid, i_instr, i_alu_data, i_dbg_reg,
    input  o_instr_ready, o_alu_opcode, o_alu_extra, o_alu_data1, o_alu_data2,
           o_wb_valid, o_wb_reg, o_wb_data, o_illegal, o_dbg_data
  );
endinterface

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer: accept, decode operands from a 4x16 register file,
// capture the external ALU result, then write back (or flag an unsupported opcode).
module alu_sequencer #(
  parameter logic [15:0] REG_RESET = 16'h0000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  alu_sequencer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_WB     = 2'd3;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_SHIFT = 4'd4;
  localparam logic [3:0] OP_MOVE  = 4'd7;
  localparam logic [3:0] OP_LOADC = 4'd9;

  logic [1:0]  state;
  logic [15:0] instr_p0;
  logic [15:0] regs [4];
  logic [3:0]  alu_opcode_p1;
  logic [1:0]  alu_extra_p1;
  logic [15:0] alu_data1_p1;
  logic [15:0] alu_data2_p1;
  logic [15:0] result_p2;

  logic        accept;
  logic        wb_write;
  logic        wb_illegal;
  logic [3:0]  op_q;
  logic [1:0]  rd_q;
  logic [1:0]  extra_q;
  logic [7:0]  imm_q;

  function automatic logic uses_alu(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SHIFT) || (op == OP_MOVE);
  endfunction

  function automatic logic writes_back(input logic [3:0] op);
    return uses_alu(op) || (op == OP_LOADC);
  endfunction

  assign op_q    = instr_p0[15:12];
  assign rd_q    = instr_p0[11:10];
  assign extra_q = instr_p0[9:8];
  assign imm_q   = instr_p0[7:0];

  assign accept     = (state == ST_IDLE) && bus.i_instr_valid;
  assign wb_write   = (state == ST_WB) && writes_back(op_q);
  assign wb_illegal = (state == ST_WB) && !writes_back(op_q);

  assign bus.o_instr_ready = (state == ST_IDLE);
  assign bus.o_alu_opcode  = alu_opcode_p1;
  assign bus.o_alu_extra   = alu_extra_p1;
  assign bus.o_alu_data1   = alu_data1_p1;
  assign bus.o_alu_data2   = alu_data2_p1;
  assign bus.o_wb_valid    = wb_write;
  assign bus.o_wb_reg      = wb_write ? rd_q : 2'd0;
  assign bus.o_wb_data     = wb_write ? result_p2 : 16'h0000;
  assign bus.o_illegal     = wb_illegal;
  assign bus.o_dbg_data    = regs[bus.i_dbg_reg];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   state <= accept ? ST_DECODE : ST_IDLE;
        ST_DECODE: state <= ST_EXEC;
        ST_EXEC:   state <= ST_WB;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  // p0: instruction capture on the accept edge
  always_ff @(posedge i_clk) begin
    if (accept) begin
      instr_p0 <= bus.i_instr;
    end
  end

  // p1: operands registered in DECODE, held through EXEC/WB, cleared on return to IDLE
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alu_opcode_p1 <= 4'd0;
      alu_extra_p1  <= 2'd0;
      alu_data1_p1  <= 16'h0000;
      alu_data2_p1  <= 16'h0000;
    end else if (state == ST_DECODE) begin
      alu_opcode_p1 <= op_q;
      alu_extra_p1  <= extra_q;
      alu_data1_p1  <= regs[rd_q];
      alu_data2_p1  <= extra_q[1] ? {8'h00, imm_q} : regs[imm_q[1:0]];
    end else if (state == ST_WB) begin
      alu_opcode_p1 <= 4'd0;
      alu_extra_p1  <= 2'd0;
      alu_data1_p1  <= 16'h0000;
      alu_data2_p1  <= 16'h0000;
    end
  end

  // p2: result capture in EXEC; LOADC bypasses the ALU entirely
  always_ff @(posedge i_clk) begin
    if (state == ST_EXEC) begin
      result_p2 <= (op_q == OP_LOADC) ? {8'h00, imm_q} : bus.i_alu_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= REG_RESET;
      end
    end else if (wb_write) begin
      regs[rd_q] <= result_p2;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: the driver queues expected retirements from a
// register-file model, and a negedge monitor pops and compares each writeback/illegal pulse.
module tb_alu_sequencer;

  localparam logic [15:0] RR = 16'h1234;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  alu_sequencer_if bus();

  alu_sequencer #(.REG_RESET(RR)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    bit          ill;
    logic [3:0]  op;
    logic [1:0]  ex;
    logic [1:0]  rd;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] mregs[4];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_acc = -100;

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a << b[3:0];
      4'd7:    return b;
      default: return 16'hDEAD;
    endcase
  endfunction

  function automatic logic [15:0] mk(input int op, input int rd, input int ex, input int imm);
    return {4'(op), 2'(rd), 2'(ex), 8'(imm)};
  endfunction

  // External combinational ALU
  always_comb begin
    bus.i_alu_data = alu_fn(bus.o_alu_opcode, bus.o_alu_data1, bus.o_alu_data2);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    tests++;
    if (act !== ex) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, ex, $time);
    end
  endtask

  task automatic predict(input logic [15:0] ins);
    exp_t e;
    e.op  = ins[15:12];
    e.rd  = ins[11:10];
    e.ex  = ins[9:8];
    e.d1  = mregs[e.rd];
    e.d2  = e.ex[1] ? {8'h00, ins[7:0]} : mregs[ins[1:0]];
    e.cyc = cyc + 3;
    e.ill = 1'b0;
    if (e.op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7})
      e.data = alu_fn(e.op, e.d1, e.d2);
    else if (e.op == 4'd9)
      e.data = {8'h00, ins[7:0]};
    else begin
      e.ill  = 1'b1;
      e.data = 16'h0000;
    end
    if (!e.ill) mregs[e.rd] = e.data;
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [15:0] ins, input bit track, input bit hold, input bit burst);
    int waited = 0;
    bus.i_instr       = ins;
    bus.i_instr_valid = 1'b1;
    @(negedge clk);
    while (!bus.o_instr_ready && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.o_instr_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      bus.i_instr_valid = 1'b0;
      return;
    end
    if (burst) chk("accept_spacing", cyc - last_acc, 32'd4);
    last_acc = cyc;
    if (track) predict(ins);
    @(posedge clk);
    #1;
    if (!hold) bus.i_instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!bus.o_instr_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.o_instr_ready) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      bus.i_dbg_reg = 2'(i);
      #1;
      chk($sformatf("dbg_r%0d", i), bus.o_dbg_data, mregs[i]);
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    chk({nm, "_ready"}, bus.o_instr_ready, 1);
    chk({nm, "_alu"}, {bus.o_alu_opcode, bus.o_alu_extra, bus.o_alu_data1}, 0);
    chk({nm, "_alu2"}, bus.o_alu_data2, 0);
    chk({nm, "_wb"}, {bus.o_wb_valid, bus.o_illegal, bus.o_wb_reg, bus.o_wb_data}, 0);
  endtask

  // Monitor: every retirement must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_wb_valid || bus.o_illegal) begin
        if (q.size() == 0) begin
          chk("unexpected_retire", {bus.o_wb_valid, bus.o_illegal}, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("retire_cycle", cyc, e.cyc);
          chk("wb_valid", bus.o_wb_valid, !e.ill);
          chk("illegal", bus.o_illegal, e.ill);
          chk("alu_op_ex", {bus.o_alu_opcode, bus.o_alu_extra}, {e.op, e.ex});
          chk("alu_data1", bus.o_alu_data1, e.d1);
          chk("alu_data2", bus.o_alu_data2, e.d2);
          if (!e.ill) begin
            chk("wb_reg", bus.o_wb_reg, e.rd);
            chk("wb_data", bus.o_wb_data, e.data);
          end
        end
      end
      if (!bus.o_wb_valid) chk("wb_zero", {bus.o_wb_reg, bus.o_wb_data}, 0);
      if (bus.o_instr_ready) chk("idle_alu_zero", {bus.o_alu_opcode, bus.o_alu_data1, bus.o_alu_data2}, 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    bus.i_instr_valid = 1'b0;
    bus.i_instr       = 16'h0000;
    bus.i_dbg_reg     = 2'd0;
    rst               = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) mregs[i] = RR;
    check_idle_outputs("reset");
    check_regs();

    // LOADC r1,0x34; LOADC r2,0x12; ADD r1,r2 -> r1 = 0x0046
    issue(mk(9, 1, 0, 8'h34), 1, 0, 0);
    issue(mk(9, 2, 0, 8'h12), 1, 0, 0);
    issue(mk(0, 1, 0, 2), 1, 0, 0);
    wait_idle();
    chk("add_model_r1", mregs[1], 16'h0046);
    check_regs();

    // r0=1; SHIFT r0 by immediate 4 -> 0x0010
    issue(mk(9, 0, 0, 1), 1, 0, 0);
    issue(mk(4, 0, 3, 4), 1, 0, 0);
    wait_idle();
    check_regs();

    // LOAD is unsupported: illegal pulse, no register change
    issue(mk(5, 2, 0, 8'hFF), 1, 0, 0);
    wait_idle();
    check_regs();

    // SUB r1,r1 with r1=5 reads the same pre-write operand twice
    issue(mk(9, 1, 0, 5), 1, 0, 0);
    issue(mk(1, 1, 0, 1), 1, 0, 0);
    wait_idle();
    check_regs();

    // Valid held high: one accept every 4 cycles, nothing dropped or duplicated
    for (int k = 0; k < 8; k++)
      issue(16'($urandom), 1, 1, k > 0);
    bus.i_instr_valid = 1'b0;
    wait_idle();
    check_regs();

    // Reset during EXEC of ADD r3,r3 aborts it
    issue(mk(9, 3, 0, 7), 1, 0, 0);
    issue(mk(0, 3, 0, 3), 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) mregs[i] = RR;
    check_idle_outputs("abort");
    check_regs();

    // Reset wins over a simultaneous accept
    bus.i_instr       = mk(9, 0, 0, 8'h77);
    bus.i_instr_valid = 1'b1;
    rst               = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.i_instr_valid = 1'b0;
    check_idle_outputs("rst_prio");
    @(posedge clk);
    #1;
    check_regs();

    // Random traffic with idle gaps and valid pulses withdrawn while busy
    for (int k = 0; k < 40; k++) begin
      issue(16'($urandom), 1, 0, 0);
      if ($urandom_range(0, 2) == 0) begin
        bus.i_instr       = 16'($urandom);
        bus.i_instr_valid = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 bus.i_instr_valid = 1'b0;
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    begin
      int n = 0;
      while (q.size() != 0 && n < 50) begin
        @(posedge clk);
        n++;
      end
      #1;
      chk("drain", q.size(), 0);
    end
    wait_idle();
    check_regs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
